c10_tape_encoder: RTL and testbench
===================================

// Module: c10_tape_encoder
// PURPOSE
// Cassette playback stage between the SDRAM byte store and the mc10 cassette input.
// Fetches the loaded .c10 image one byte at a time over the sdram rd/addr/data handshake.
// Serialises each byte LSB first into MC-10 FSK: '1' = one 2400 Hz cycle, '0' = one 1200 Hz cycle.
// Drives data (to cin, tape audio and overlay) plus a 3-bit status word.
// PARAMETERS
// HALF_ONE   833   clk cycles per half-period of a '1' bit (4 MHz / 4800)
// HALF_ZERO  1667  clk cycles per half-period of a '0' bit (4 MHz / 2400)
// RD_LAT     8     clk cycles from sdram_rd pulse until sdram_data is valid
// ADDR_W     25    byte address / length width
// PORTS
// clk          in   1       tape clock (clk_4)
// reset_n      in   1       asynchronous, active-low reset
// play         in   1       play/pause request; rising edge toggles
// rewind       in   1       rewind request; rising edge acts
// tape_len     in   ADDR_W  bytes in loaded image; 0 = no tape
// sdram_addr   out  ADDR_W  byte address being fetched
// sdram_rd     out  1       one-cycle read strobe
// sdram_data   in   8       read data, valid RD_LAT cycles after sdram_rd
// data         out  1       FSK tape waveform
// status       out  3       {eot, paused, playing}
// BEHAVIOUR
// - Reset (async, reset_n=0): state IDLE, sdram_addr=0, sdram_rd=0, data=0, status=3'b000, bit/half/delay counters=0, edge regs=0.
// - play and rewind are synchronous to clk. Each is edge-detected with a registered copy; only the 0->1 transition acts.
// - States: IDLE, FETCH, WAIT, SEND, PAUSE, EOT.
// - IDLE: on play edge with tape_len!=0 -> FETCH. Play edge with tape_len==0 is ignored.
// - FETCH: sdram_rd=1 for exactly one cycle at the current sdram_addr -> WAIT.
// - WAIT: count RD_LAT cycles, then latch sdram_data into the shift reg, set bit index 0 -> SEND.
// - SEND: each bit is data=1 for H cycles, then data=0 for H cycles, with H = bit ? HALF_ONE : HALF_ZERO.
// - SEND, after bit 7 completes: sdram_addr+=1; if sdram_addr+1 == tape_len -> EOT, else -> FETCH.
//   - No gap is inserted between bytes beyond FETCH+WAIT (RD_LAT+1 cycles), with data=0 during that gap.
// - Pause: a play edge while in FETCH/WAIT/SEND sets a pause flag.
//   - The current bit, or the pending fetch/latch, completes first; then the block goes to PAUSE with data=0.
//   - No byte is lost: on resume, SEND restarts at the next unsent bit of the latched byte.
// - PAUSE: on play edge -> resume at the saved point (SEND, or FETCH if the byte was finished).
// - EOT: data=0. A play edge is ignored; only rewind leaves EOT.
// - Rewind edge, any state: sdram_addr=0, pause flag cleared, state IDLE, data=0 next cycle.
//   - An in-flight WAIT is abandoned and its data discarded.
// - Simultaneous play and rewind edges: rewind wins and play is ignored.
// - status[0] = state in {FETCH, WAIT, SEND} and pause flag clear.
// - status[1] = state==PAUSE, or (state==IDLE and sdram_addr!=0).
// - status[2] = state==EOT.
// - status is registered and updates the cycle after the state change.
// - tape_len changing mid-play: compared live at each byte end. If sdram_addr+1 >= tape_len -> EOT.
// - sdram_addr never exceeds tape_len-1 while fetching and does not wrap.
// TESTING (bench: HALF_ONE=2, HALF_ZERO=4, RD_LAT=3)
// - Reset mid-SEND (reset_n low 1 cycle) -> data=0, status=000, sdram_addr=0, sdram_rd=0 immediately, no further rd.
// - tape_len=1, byte 8'h01, play edge -> one rd at addr 0, then data high2/low2, then 7x (high4/low4), then status=100.
// - tape_len=2, bytes A5,3C -> rd at 0 then 1, bit sequence 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0; eot after byte 2.
// - Play edge during bit 3 of 8'hFF -> bit 3 finishes, status=010, data=0; play again -> bits 4..7 resume, total 8 cycles of '1'.
// - Rewind at EOT and simultaneous play+rewind mid-SEND -> addr=0, status=000, IDLE; next play re-reads addr 0.
// - tape_len=0, play edge -> no sdram_rd, status stays 000.

Source files
------------

// File: rtl/c10_tape_encoder.sv
// -----------------------------------------------------------------------------
// c10_tape_encoder
// Cassette playback stage between the SDRAM byte store and the MC-10 cassette
// input. Fetches the loaded .c10 image one byte at a time and serialises each
// byte LSB first as FSK: a '1' is one short cycle (HALF_ONE high, HALF_ONE
// low), a '0' is one long cycle (HALF_ZERO high, HALF_ZERO low).
//
// Ports
//   clk         in   1       tape clock (clk_4)
//   reset_n     in   1       asynchronous active-low reset
//   play        in   1       play/pause request, 0->1 edge acts
//   rewind      in   1       rewind request, 0->1 edge acts
//   tape_len    in   ADDR_W  bytes in loaded image, 0 = no tape
//   sdram_addr  out  ADDR_W  byte address being fetched
//   sdram_rd    out  1       one-cycle read strobe
//   sdram_data  in   8       read data
//   data        out  1       FSK tape waveform
//   status      out  3       {eot, paused, playing}, registered
//   dbg_state   out  3       current FSM state encoding
//
// Read handshake: sdram_rd is a single-cycle strobe with sdram_addr stable;
// there is no ready/valid back-pressure. sdram_data is sampled exactly RD_LAT
// cycles after the strobe cycle, and sdram_addr is held until the byte is
// latched.
// -----------------------------------------------------------------------------
module c10_tape_encoder #(
  parameter int HALF_ONE  = 833,
  parameter int HALF_ZERO = 1667,
  parameter int RD_LAT    = 8,
  parameter int ADDR_W    = 25
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              play,
  input  logic              rewind,
  input  logic [ADDR_W-1:0] tape_len,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic              sdram_rd,
  input  logic [7:0]        sdram_data,
  output logic              data,
  output logic [2:0]        status,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_SEND  = 3'd3,
    S_PAUSE = 3'd4,
    S_EOT   = 3'd5
  } state_t;

  // One counter serves both the half-period timer and the read-latency wait.
  localparam int CNT_MAX_H = (HALF_ONE > HALF_ZERO) ? HALF_ONE : HALF_ZERO;
  localparam int CNT_MAX   = (CNT_MAX_H > RD_LAT) ? CNT_MAX_H : RD_LAT;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]  ONE_LAST  = CNT_W'(HALF_ONE - 1);
  localparam logic [CNT_W-1:0]  ZERO_LAST = CNT_W'(HALF_ZERO - 1);
  localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_rd;
  logic                r_data;
  logic [2:0]          r_status;
  logic                r_play_q;
  logic                r_rew_q;
  logic [7:0]          r_shift;
  logic [2:0]          r_bit_idx;
  logic                r_low_half;   // 0: high half of the bit, 1: low half
  logic [CNT_W-1:0]    r_cnt;
  logic                r_pause;      // pause requested, honoured at next safe point
  logic                r_resume_fetch; // paused between bytes: resume with a fetch

  logic                w_play_edge;
  logic                w_rew_edge;
  logic                w_cur_bit;
  logic                w_half_last;
  logic                w_pause_now;
  logic                w_at_end;
  logic [ADDR_W:0]     w_next_addr_ext;
  logic [2:0]          w_status;

  assign w_play_edge = play & ~r_play_q;
  assign w_rew_edge  = rewind & ~r_rew_q;
  assign w_cur_bit   = r_shift[r_bit_idx];
  assign w_half_last = (r_cnt == (w_cur_bit ? ONE_LAST : ZERO_LAST));
  // A play edge arriving on the very cycle a bit/latch completes still pauses.
  assign w_pause_now = r_pause | w_play_edge;

  // Extra bit so the end-of-tape compare can never wrap; tape_len is read
  // live so a shrinking image still stops cleanly.
  assign w_next_addr_ext = {1'b0, r_addr} + {{ADDR_W{1'b0}}, 1'b1};
  assign w_at_end        = (w_next_addr_ext >= {1'b0, tape_len});

  always_comb begin
    w_status    = 3'b000;
    w_status[0] = ((r_state == S_FETCH) || (r_state == S_WAIT) ||
                   (r_state == S_SEND)) && !r_pause;
    w_status[1] = (r_state == S_PAUSE) ||
                  ((r_state == S_IDLE) && (r_addr != '0));
    w_status[2] = (r_state == S_EOT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_addr         <= '0;
      r_rd           <= 1'b0;
      r_data         <= 1'b0;
      r_status       <= 3'b000;
      r_play_q       <= 1'b0;
      r_rew_q        <= 1'b0;
      r_shift        <= 8'h00;
      r_bit_idx      <= 3'd0;
      r_low_half     <= 1'b0;
      r_cnt          <= '0;
      r_pause        <= 1'b0;
      r_resume_fetch <= 1'b0;
    end else begin
      r_play_q <= play;
      r_rew_q  <= rewind;
      r_rd     <= 1'b0;
      r_status <= w_status;

      if (w_rew_edge) begin
        // Rewind beats everything, including a simultaneous play edge and
        // an outstanding read whose data is simply never latched.
        r_state        <= S_IDLE;
        r_addr         <= '0;
        r_data         <= 1'b0;
        r_pause        <= 1'b0;
        r_resume_fetch <= 1'b0;
        r_cnt          <= '0;
        r_low_half     <= 1'b0;
        r_bit_idx      <= 3'd0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_play_edge && (tape_len != '0)) begin
              r_state <= S_FETCH;
              r_rd    <= 1'b1;
            end
          end

          S_FETCH: begin
            if (w_play_edge) r_pause <= 1'b1;
            r_state <= S_WAIT;
            r_cnt   <= '0;
          end

          S_WAIT: begin
            if (w_play_edge) r_pause <= 1'b1;
            if (r_cnt == WAIT_LAST) begin
              r_shift    <= sdram_data;
              r_bit_idx  <= 3'd0;
              r_cnt      <= '0;
              r_low_half <= 1'b0;
              if (w_pause_now) begin
                r_state        <= S_PAUSE;
                r_resume_fetch <= 1'b0;
                r_data         <= 1'b0;
              end else begin
                r_state <= S_SEND;
                r_data  <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end

          S_SEND: begin
            if (w_play_edge) r_pause <= 1'b1;
            if (w_half_last) begin
              r_cnt <= '0;
              if (!r_low_half) begin
                r_low_half <= 1'b1;
                r_data     <= 1'b0;
              end else begin
                // Bit complete; data is already 0 for any gap that follows.
                r_low_half <= 1'b0;
                if (r_bit_idx == 3'd7) begin
                  r_addr    <= r_addr + ADDR_ONE;
                  r_bit_idx <= 3'd0;
                  if (w_at_end) begin
                    r_state <= S_EOT;
                    r_pause <= 1'b0;
                  end else if (w_pause_now) begin
                    r_state        <= S_PAUSE;
                    r_resume_fetch <= 1'b1;
                  end else begin
                    r_state <= S_FETCH;
                    r_rd    <= 1'b1;
                  end
                end else begin
                  r_bit_idx <= r_bit_idx + 3'd1;
                  if (w_pause_now) begin
                    r_state        <= S_PAUSE;
                    r_resume_fetch <= 1'b0;
                  end else begin
                    r_data <= 1'b1;
                  end
                end
              end
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end

          S_PAUSE: begin
            if (w_play_edge) begin
              r_pause <= 1'b0;
              if (r_resume_fetch) begin
                // The image may have been shortened while paused.
                if (r_addr >= tape_len) begin
                  r_state <= S_EOT;
                end else begin
                  r_state <= S_FETCH;
                  r_rd    <= 1'b1;
                end
              end else begin
                // r_bit_idx already points at the next unsent bit.
                r_state    <= S_SEND;
                r_data     <= 1'b1;
                r_cnt      <= '0;
                r_low_half <= 1'b0;
              end
            end
          end

          S_EOT: begin
            r_data <= 1'b0;
          end

          default: begin
            r_state <= S_IDLE;
            r_data  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sdram_addr = r_addr;
  assign sdram_rd   = r_rd;
  assign data       = r_data;
  assign status     = r_status;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_c10_tape_encoder.sv
// -----------------------------------------------------------------------------
// tb_c10_tape_encoder
// Directed bench for c10_tape_encoder with short FSK timing (HALF_ONE=2,
// HALF_ZERO=4, RD_LAT=3). Inputs are driven and outputs sampled 1 time unit
// after each rising clock edge. A small SDRAM model answers each read strobe
// with the byte valid for exactly one cycle, RD_LAT cycles after the strobe.
// Every read strobe seen is logged and compared against the expected address
// list at the end.
// -----------------------------------------------------------------------------
module tb_c10_tape_encoder;

  localparam int HALF_ONE  = 2;
  localparam int HALF_ZERO = 4;
  localparam int RD_LAT    = 3;
  localparam int ADDR_W    = 25;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic              play = 1'b0;
  logic              rewind = 1'b0;
  logic [ADDR_W-1:0] tape_len = '0;
  logic [ADDR_W-1:0] sdram_addr;
  logic              sdram_rd;
  logic [7:0]        sdram_data = 8'h00;
  logic              data;
  logic [2:0]        status;
  logic [2:0]        dbg_state;

  c10_tape_encoder #(
    .HALF_ONE (HALF_ONE),
    .HALF_ZERO(HALF_ZERO),
    .RD_LAT   (RD_LAT),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .play      (play),
    .rewind    (rewind),
    .tape_len  (tape_len),
    .sdram_addr(sdram_addr),
    .sdram_rd  (sdram_rd),
    .sdram_data(sdram_data),
    .data      (data),
    .status    (status),
    .dbg_state (dbg_state)
  );

  // ---------------- SDRAM model ----------------
  logic [7:0] mem [0:3];
  logic [7:0] m_pend = 8'h00;
  int         m_cnt = 0;

  always @(posedge clk) begin
    if (sdram_rd) begin
      m_cnt  <= 1;
      m_pend <= mem[sdram_addr[1:0]];
    end else if (m_cnt != 0) begin
      if (m_cnt == RD_LAT - 1) sdram_data <= m_pend;
      if (m_cnt == RD_LAT) begin
        sdram_data <= ~m_pend;   // junk outside the valid cycle
        m_cnt      <= 0;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [ADDR_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] act_q[$];

  always @(negedge clk) begin
    if (sdram_rd) act_q.push_back(sdram_addr);
  end

  int n_checks = 0;
  int n_errors = 0;
  int hi_cycles = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic play_pulse();
    play = 1'b1;
    tick();
    play = 1'b0;
  endtask

  task automatic rewind_pulse();
    rewind = 1'b1;
    tick();
    rewind = 1'b0;
  endtask

  // Called on the FETCH cycle: data must stay low for FETCH + RD_LAT waits.
  task automatic check_gap(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i <= RD_LAT; i++) begin
      if (data !== 1'b0) bad++;
      tick();
    end
    check(tag, bad, 0);
  endtask

  // Checks bits first..last of byte b, starting on the first high cycle.
  task automatic check_wave(input string tag, input logic [7:0] b, input int first, input int last);
    int h;
    int bad_hi;
    int bad_lo;
    for (int i = first; i <= last; i++) begin
      h = b[i] ? HALF_ONE : HALF_ZERO;
      bad_hi = 0;
      bad_lo = 0;
      for (int c = 0; c < h; c++) begin
        if (data !== 1'b1) bad_hi++;
        else hi_cycles++;
        tick();
      end
      for (int c = 0; c < h; c++) begin
        if (data !== 1'b0) bad_lo++;
        tick();
      end
      check($sformatf("%s_bit%0d_hi", tag, i), bad_hi, 0);
      check($sformatf("%s_bit%0d_lo", tag, i), bad_lo, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int bad;
    mem[0] = 8'h00; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'h00;

    // Reset state
    tick();
    tick();
    check("rst_data", data, 0);
    check("rst_status", status, 3'b000);
    check("rst_addr", sdram_addr, 0);
    check("rst_rd", sdram_rd, 0);
    reset_n = 1'b1;
    tick();

    // No tape: play edge ignored
    tape_len = 0;
    play_pulse();
    check("notape_rd", sdram_rd, 0);
    repeat (5) tick();
    check("notape_status", status, 3'b000);

    // One byte 8'h01
    mem[0] = 8'h01;
    tape_len = 1;
    play_pulse();
    exp_q.push_back(0);
    check("t1_rd", sdram_rd, 1);
    check("t1_addr", sdram_addr, 0);
    check_gap("t1_gap");
    check("t1_status_play", status, 3'b001);
    check_wave("t1", 8'h01, 0, 7);
    check("t1_end_data", data, 0);
    check("t1_end_rd", sdram_rd, 0);
    check("t1_status_lag", status, 3'b001);
    tick();
    check("t1_status_eot", status, 3'b100);
    play_pulse();
    repeat (4) tick();
    check("t1_eot_play_ignored", status, 3'b100);
    check("t1_eot_data", data, 0);
    rewind_pulse();
    tick();
    check("t1_rew_status", status, 3'b000);
    check("t1_rew_addr", sdram_addr, 0);

    // Two bytes A5, 3C
    mem[0] = 8'hA5;
    mem[1] = 8'h3C;
    tape_len = 2;
    play_pulse();
    exp_q.push_back(0);
    check("t2_rd0", sdram_rd, 1);
    check("t2_addr0", sdram_addr, 0);
    check_gap("t2_gap0");
    check_wave("t2_b0", 8'hA5, 0, 7);
    exp_q.push_back(1);
    check("t2_rd1", sdram_rd, 1);
    check("t2_addr1", sdram_addr, 1);
    check_gap("t2_gap1");
    check_wave("t2_b1", 8'h3C, 0, 7);
    check("t2_status_lag", status, 3'b001);
    tick();
    check("t2_status_eot", status, 3'b100);
    rewind_pulse();
    tick();
    check("t2_rew_status", status, 3'b000);

    // Pause during bit 3 of 8'hFF
    mem[0] = 8'hFF;
    tape_len = 1;
    play_pulse();
    exp_q.push_back(0);
    check("t3_rd", sdram_rd, 1);
    check_gap("t3_gap");
    check_wave("t3_pre", 8'hFF, 0, 2);
    check("t3_b3_hi0", data, 1);
    play = 1'b1;
    tick();
    play = 1'b0;
    check("t3_b3_hi1", data, 1);
    tick();
    check("t3_b3_lo0", data, 0);
    check("t3_status_pending", status, 3'b000);
    tick();
    check("t3_b3_lo1", data, 0);
    tick();
    check("t3_pause_data", data, 0);
    tick();
    check("t3_status_paused", status, 3'b010);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (data !== 1'b0 || sdram_rd !== 1'b0) bad++;
      tick();
    end
    check("t3_pause_hold", bad, 0);
    check("t3_status_hold", status, 3'b010);
    play = 1'b1;
    tick();
    play = 1'b0;
    hi_cycles = 0;
    check_wave("t3_post", 8'hFF, 4, 7);
    check("t3_hi_cycles", hi_cycles, 8);
    tick();
    check("t3_status_eot", status, 3'b100);
    rewind_pulse();
    tick();

    // Simultaneous play + rewind mid-SEND of byte 1
    mem[0] = 8'hA5;
    mem[1] = 8'h3C;
    tape_len = 2;
    play_pulse();
    exp_q.push_back(0);
    check_gap("t4_gap0");
    check_wave("t4_b0", 8'hA5, 0, 7);
    exp_q.push_back(1);
    check("t4_addr1", sdram_addr, 1);
    check_gap("t4_gap1");
    check_wave("t4_b1", 8'h3C, 0, 1);
    play = 1'b1;
    rewind = 1'b1;
    tick();
    play = 1'b0;
    rewind = 1'b0;
    check("t4_rew_data", data, 0);
    check("t4_rew_addr", sdram_addr, 0);
    check("t4_rew_rd", sdram_rd, 0);
    tick();
    check("t4_rew_status", status, 3'b000);
    repeat (5) tick();
    check("t4_idle_status", status, 3'b000);
    play_pulse();
    exp_q.push_back(0);
    check("t4_reread_rd", sdram_rd, 1);
    check("t4_reread_addr", sdram_addr, 0);
    tick();
    rewind_pulse();     // abandon the WAIT
    bad = 0;
    for (int i = 0; i < RD_LAT + 4; i++) begin
      if (data !== 1'b0) bad++;
      tick();
    end
    check("t4_abandon_data", bad, 0);
    check("t4_abandon_status", status, 3'b000);

    // Asynchronous reset mid-SEND of byte 1
    play_pulse();
    exp_q.push_back(0);
    check_gap("t6_gap0");
    check_wave("t6_b0", 8'hA5, 0, 7);
    exp_q.push_back(1);
    check_gap("t6_gap1");
    check_wave("t6_b1", 8'h3C, 0, 2);
    check("t6_pre_data", data, 1);
    reset_n = 1'b0;
    #1;
    check("t6_rst_data", data, 0);
    check("t6_rst_status", status, 3'b000);
    check("t6_rst_addr", sdram_addr, 0);
    check("t6_rst_rd", sdram_rd, 0);
    tick();
    reset_n = 1'b1;
    repeat (10) tick();
    check("t6_post_status", status, 3'b000);
    check("t6_post_data", data, 0);

    // Read strobe log
    check("sb_count", act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < act_q.size())
        check($sformatf("sb_addr%0d", i), act_q[i], exp_q[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
